// File: rtl/ds_pkg.sv
// Shared constants for the decode-side operand stage: bypass source indices and default widths.
// Bypass index 0 is the youngest producer and always wins a priority tie.
package ds_pkg;

  localparam int DS_DATA_W      = 32;
  localparam int DS_RADDR_W     = 5;
  localparam int DS_NUM_FWD     = 3;
  localparam int DS_PAYLOAD_W   = 64;
  localparam int DS_STALL_CNT_W = 16;

  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

endpackage

// File: rtl/ds_fwd_mux.sv
// One source operand: bypass match, youngest-first select, resolved value and interlock flag.
// Purely combinational; DS_BYPASS_EN selects full forwarding, otherwise any match on a used operand interlocks.
module ds_fwd_mux
  import ds_pkg::*;
#(
  parameter int DATA_W  = DS_DATA_W,
  parameter int RADDR_W = DS_RADDR_W,
  parameter int NUM_FWD = DS_NUM_FWD
) (
  input  logic [RADDR_W-1:0]         i_src,
  input  logic                       i_used,
  input  logic [DATA_W-1:0]          i_rf_rdata,
  input  logic [NUM_FWD-1:0]         i_fwd_we,
  input  logic [NUM_FWD*RADDR_W-1:0] i_fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]  i_fwd_data,
  input  logic [NUM_FWD-1:0]         i_fwd_rdy,
  output logic [DATA_W-1:0]          o_value,
  output logic                       o_hazard
);

  logic               w_src_nz;
  logic [NUM_FWD-1:0] w_match;
  logic               w_hit;

  assign w_src_nz = |i_src;

  // Register 0 never matches a producer, so a write to r0 can neither bypass nor stall.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_FWD; i++) begin
      w_match[i] = i_fwd_we[i] && (i_fwd_addr[i*RADDR_W +: RADDR_W] == i_src) && w_src_nz;
    end
  end

  assign w_hit = |w_match;

`ifdef DS_BYPASS_EN
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_rdy;

  // Walk oldest to youngest so the lowest matching index is the last one written.
  always_comb begin
    w_sel_data = '0;
    w_sel_rdy  = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_sel_data = i_fwd_data[i*DATA_W +: DATA_W];
        w_sel_rdy  = i_fwd_rdy[i];
      end
    end
  end

  assign o_value  = !w_src_nz ? '0 : (w_hit ? w_sel_data : i_rf_rdata);
  assign o_hazard = i_used && w_hit && !w_sel_rdy;
`else
  logic w_unused_fwd;

  assign w_unused_fwd = ^{i_fwd_data, i_fwd_rdy};
  assign o_value      = w_src_nz ? i_rf_rdata : '0;
  assign o_hazard     = i_used && w_hit;
`endif

endmodule

// File: rtl/ds_operand_stage.sv
// Decode operand slot: holds one instruction, resolves rs/rt via bypass or regfile, offers it 1 cycle after capture.
// Backpressure: in_allowin drops while an operand interlocks or downstream refuses; flush squashes the slot. Macro: DS_BYPASS_EN.
module ds_operand_stage
  import ds_pkg::*;
#(
  parameter int DATA_W      = DS_DATA_W,
  parameter int RADDR_W     = DS_RADDR_W,
  parameter int NUM_FWD     = DS_NUM_FWD,
  parameter int PAYLOAD_W   = DS_PAYLOAD_W,
  parameter int STALL_CNT_W = DS_STALL_CNT_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_allowin,
  input  logic [RADDR_W-1:0]         in_rs_addr,
  input  logic [RADDR_W-1:0]         in_rt_addr,
  input  logic                       in_rs_used,
  input  logic                       in_rt_used,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  output logic [RADDR_W-1:0]         rf_raddr1,
  output logic [RADDR_W-1:0]         rf_raddr2,
  input  logic [DATA_W-1:0]          rf_rdata1,
  input  logic [DATA_W-1:0]          rf_rdata2,
  input  logic [NUM_FWD-1:0]         fwd_we,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
  input  logic [NUM_FWD-1:0]         fwd_rdy,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_allowin,
  output logic [DATA_W-1:0]          out_rs_value,
  output logic [DATA_W-1:0]          out_rt_value,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [STALL_CNT_W-1:0]     stall_cnt
);

  logic                   r_valid;
  logic [RADDR_W-1:0]     r_rs;
  logic [RADDR_W-1:0]     r_rt;
  logic                   r_rs_used;
  logic                   r_rt_used;
  logic [PAYLOAD_W-1:0]   r_payload;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_haz_rs;
  logic w_haz_rt;
  logic w_ready_go;
  logic w_hold;
  logic w_capture;

  ds_fwd_mux #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W),
    .NUM_FWD (NUM_FWD)
  ) u_rs_mux (
    .i_src      (r_rs),
    .i_used     (r_rs_used),
    .i_rf_rdata (rf_rdata1),
    .i_fwd_we   (fwd_we),
    .i_fwd_addr (fwd_addr),
    .i_fwd_data (fwd_data),
    .i_fwd_rdy  (fwd_rdy),
    .o_value    (out_rs_value),
    .o_hazard   (w_haz_rs)
  );

  ds_fwd_mux #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W),
    .NUM_FWD (NUM_FWD)
  ) u_rt_mux (
    .i_src      (r_rt),
    .i_used     (r_rt_used),
    .i_rf_rdata (rf_rdata2),
    .i_fwd_we   (fwd_we),
    .i_fwd_addr (fwd_addr),
    .i_fwd_data (fwd_data),
    .i_fwd_rdy  (fwd_rdy),
    .o_value    (out_rt_value),
    .o_hazard   (w_haz_rt)
  );

  assign w_ready_go  = !(w_haz_rs || w_haz_rt);
  assign w_hold      = r_valid && !w_ready_go;
  assign in_allowin  = !r_valid || (w_ready_go && out_allowin);
  assign out_valid   = r_valid && w_ready_go && !flush;
  assign w_capture   = in_valid && in_allowin && !flush;

  assign rf_raddr1   = r_rs;
  assign rf_raddr2   = r_rt;
  assign out_payload = r_payload;
  assign stall_cnt   = r_stall_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid     <= 1'b0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rs_used   <= 1'b0;
      r_rt_used   <= 1'b0;
      r_payload   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (in_allowin) begin
        r_valid <= in_valid;
      end
      if (w_capture) begin
        r_rs      <= in_rs_addr;
        r_rt      <= in_rt_addr;
        r_rs_used <= in_rs_used;
        r_rt_used <= in_rt_used;
        r_payload <= in_payload;
      end
      // Saturate rather than wrap so long stalls stay visible.
      if (w_hold && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ds_operand_stage.sv
// Directed bench for ds_operand_stage; expectations follow DS_BYPASS_EN when it is defined.
module tb_ds_operand_stage;
  import ds_pkg::*;

  localparam int SCW     = 4;
  localparam int SAT_MAX = 15;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_allowin;
  logic [4:0]  in_rs_addr, in_rt_addr;
  logic        in_rs_used, in_rt_used;
  logic [63:0] in_payload;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  fwd_we;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic [2:0]  fwd_rdy;
  logic        flush;
  logic        out_valid;
  logic        out_allowin;
  logic [31:0] out_rs_value, out_rt_value;
  logic [63:0] out_payload;
  logic [SCW-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  // Regfile stand-in: every register reads as A000_00nn.
  assign rf_rdata1 = 32'hA000_0000 | {27'd0, rf_raddr1};
  assign rf_rdata2 = 32'hA000_0000 | {27'd0, rf_raddr2};

  ds_operand_stage #(.STALL_CNT_W(SCW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_allowin   (in_allowin),
    .in_rs_addr   (in_rs_addr),
    .in_rt_addr   (in_rt_addr),
    .in_rs_used   (in_rs_used),
    .in_rt_used   (in_rt_used),
    .in_payload   (in_payload),
    .rf_raddr1    (rf_raddr1),
    .rf_raddr2    (rf_raddr2),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .fwd_we       (fwd_we),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .fwd_rdy      (fwd_rdy),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_allowin  (out_allowin),
    .out_rs_value (out_rs_value),
    .out_rt_value (out_rt_value),
    .out_payload  (out_payload),
    .stall_cnt    (stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int idx, input logic [4:0] a, input logic [31:0] d);
    fwd_addr[idx*5 +: 5]  = a;
    fwd_data[idx*32 +: 32] = d;
  endtask

  task automatic drive(input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
                       input logic [63:0] p);
    in_valid   = 1'b1;
    in_rs_addr = rs;
    in_rs_used = rsu;
    in_rt_addr = rt;
    in_rt_used = rtu;
    in_payload = p;
  endtask

  function automatic int sat(input int v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_rs_addr = '0; in_rt_addr = '0;
    in_rs_used = 1'b0; in_rt_used = 1'b0; in_payload = '0;
    fwd_we = '0; fwd_addr = '0; fwd_data = '0; fwd_rdy = '0;
    flush = 1'b0; out_allowin = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_allowin", 64'(in_allowin), 64'd1);
    chk("rst_raddr1", 64'(rf_raddr1), 64'd0);
    chk("rst_rs_value", 64'(out_rs_value), 64'd0);
    chk("rst_payload", out_payload, 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Plain capture, no producers in flight.
    drive(5'd5, 1'b1, 5'd6, 1'b1, 64'h1111_0000_0000_0001);
    #1 chk("t1_in_allowin", 64'(in_allowin), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_rs_value", 64'(out_rs_value), 64'hA000_0005);
    chk("t1_rt_value", 64'(out_rt_value), 64'hA000_0006);
    chk("t1_payload", out_payload, 64'h1111_0000_0000_0001);
    chk("t1_raddr1", 64'(rf_raddr1), 64'd5);
    chk("t1_raddr2", 64'(rf_raddr2), 64'd6);

    // EX and MEM both write rs=5, both ready.
    drive(5'd5, 1'b1, 5'd0, 1'b0, 64'h2222);
    tick();
    in_valid = 1'b0;
    set_fwd(FWD_EX, 5'd5, 32'h11);
    set_fwd(FWD_MEM, 5'd5, 32'h22);
    fwd_we = 3'b011; fwd_rdy = 3'b111;
    #1;
`ifdef DS_BYPASS_EN
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    chk("t2_rs_bypass", 64'(out_rs_value), 64'h11);
`else
    chk("t2_out_valid", 64'(out_valid), 64'd0);
    chk("t2_in_allowin", 64'(in_allowin), 64'd0);
    tick();
    exp_stall = sat(exp_stall + 1);
`endif
    fwd_we = 3'b000;
    #1;
    chk("t2_valid_after", 64'(out_valid), 64'd1);
    chk("t2_rs_rf", 64'(out_rs_value), 64'hA000_0005);
    chk("t2_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    tick();
    chk("t2_empty_valid", 64'(out_valid), 64'd0);
    chk("t2_empty_allowin", 64'(in_allowin), 64'd1);

    // Load in EX targets rt=7, not ready for two cycles.
    drive(5'd0, 1'b0, 5'd7, 1'b1, 64'h3333);
    tick();
    in_valid = 1'b0;
    set_fwd(FWD_EX, 5'd7, 32'h77);
    fwd_we = 3'b001; fwd_rdy = 3'b000;
    #1;
    chk("t3_hold_valid", 64'(out_valid), 64'd0);
    chk("t3_hold_allowin", 64'(in_allowin), 64'd0);
    tick();
    tick();
    exp_stall = sat(exp_stall + 2);
    fwd_rdy = 3'b001;
    #1;
    chk("t3_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`ifdef DS_BYPASS_EN
    chk("t3_rdy_valid", 64'(out_valid), 64'd1);
    chk("t3_rt_bypass", 64'(out_rt_value), 64'h77);
`else
    chk("t3_rdy_valid", 64'(out_valid), 64'd0);
`endif
    fwd_we = 3'b000;
    #1;
    chk("t3_left_valid", 64'(out_valid), 64'd1);
    chk("t3_rt_rf", 64'(out_rt_value), 64'hA000_0007);
    tick();

    // rs=0 with EX writing r0: value stays zero, no stall.
    drive(5'd0, 1'b1, 5'd0, 1'b0, 64'h4444);
    tick();
    in_valid = 1'b0;
    set_fwd(FWD_EX, 5'd0, 32'hFFFF_FFFF);
    fwd_we = 3'b001; fwd_rdy = 3'b001;
    #1;
    chk("t4_out_valid", 64'(out_valid), 64'd1);
    chk("t4_rs_zero", 64'(out_rs_value), 64'd0);
    tick();
    fwd_we = 3'b000;
    #1 chk("t4_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

    // rt unused, pending EX load to it: no interlock.
    drive(5'd0, 1'b0, 5'd9, 1'b0, 64'h5555);
    tick();
    in_valid = 1'b0;
    set_fwd(FWD_EX, 5'd9, 32'h99);
    fwd_we = 3'b001; fwd_rdy = 3'b000;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'd1);
`ifdef DS_BYPASS_EN
    chk("t5_rt_value", 64'(out_rt_value), 64'h99);
`else
    chk("t5_rt_value", 64'(out_rt_value), 64'hA000_0009);
`endif
    fwd_we = 3'b000;
    tick();

    // Flush while holding, with a new instruction offered.
    drive(5'd4, 1'b1, 5'd0, 1'b0, 64'h6666);
    tick();
    in_valid = 1'b0;
    set_fwd(FWD_EX, 5'd4, 32'h44);
    fwd_we = 3'b001; fwd_rdy = 3'b000;
    #1 chk("t6_hold_valid", 64'(out_valid), 64'd0);
    drive(5'd10, 1'b1, 5'd0, 1'b0, 64'h7777);
    flush = 1'b1;
    #1 chk("t6_flush_valid", 64'(out_valid), 64'd0);
    tick();
    exp_stall = sat(exp_stall + 1);
    flush = 1'b0; in_valid = 1'b0; fwd_we = 3'b000;
    #1;
    chk("t6_after_valid", 64'(out_valid), 64'd0);
    chk("t6_after_allowin", 64'(in_allowin), 64'd1);
    chk("t6_no_capture_rs", 64'(rf_raddr1), 64'd4);
    chk("t6_no_capture_pay", out_payload, 64'h6666);
    chk("t6_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

    // Flush while issuing with downstream ready: capture is still blocked.
    drive(5'd12, 1'b1, 5'd0, 1'b0, 64'h8888);
    tick();
    drive(5'd13, 1'b1, 5'd0, 1'b0, 64'h9999);
    flush = 1'b1;
    #1 chk("t6b_flush_valid", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("t6b_after_valid", 64'(out_valid), 64'd0);
    chk("t6b_no_capture_rs", 64'(rf_raddr1), 64'd12);
    chk("t6b_no_capture_pay", out_payload, 64'h8888);

    // Back-to-back issue, one per cycle.
    for (int i = 0; i < 4; i++) begin
      drive(5'(16 + i), 1'b1, 5'd0, 1'b0, 64'hB000 + 64'(i));
      tick();
      chk("t7_stream_valid", 64'(out_valid), 64'd1);
      chk("t7_stream_rs", 64'(out_rs_value), 64'hA000_0000 + 64'(16 + i));
      chk("t7_stream_pay", out_payload, 64'hB000 + 64'(i));
    end
    in_valid = 1'b0;
    tick();

    // Downstream backpressure holds the slot.
    out_allowin = 1'b0;
    drive(5'd20, 1'b1, 5'd0, 1'b0, 64'hC000);
    #1 chk("t8_empty_allowin", 64'(in_allowin), 64'd1);
    tick();
    drive(5'd21, 1'b1, 5'd0, 1'b0, 64'hC001);
    #1;
    chk("t8_bp_valid", 64'(out_valid), 64'd1);
    chk("t8_bp_allowin", 64'(in_allowin), 64'd0);
    tick();
    chk("t8_held_rs", 64'(rf_raddr1), 64'd20);
    chk("t8_held_pay", out_payload, 64'hC000);
    out_allowin = 1'b1;
    #1 chk("t8_release_allowin", 64'(in_allowin), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t8_next_rs", 64'(rf_raddr1), 64'd21);
    chk("t8_next_pay", out_payload, 64'hC001);
    tick();

    // Long WB-not-ready stall saturates the counter, then reset mid-stall.
    drive(5'd3, 1'b1, 5'd0, 1'b0, 64'hD000);
    tick();
    in_valid = 1'b0;
    set_fwd(FWD_WB, 5'd3, 32'h33);
    fwd_we = 3'b100; fwd_rdy = 3'b000;
    repeat (20) tick();
    exp_stall = sat(exp_stall + 20);
    chk("t9_stall_sat", 64'(stall_cnt), 64'(exp_stall));
    chk("t9_hold_valid", 64'(out_valid), 64'd0);
    #2 resetn = 1'b0;
    #1;
    chk("t9_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("t9_rst_valid", 64'(out_valid), 64'd0);
    chk("t9_rst_allowin", 64'(in_allowin), 64'd1);
    chk("t9_rst_raddr1", 64'(rf_raddr1), 64'd0);
    fwd_we = 3'b000;
    @(negedge clk);
    resetn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
